key_debounce_repeat: RTL and testbench

- Parametrised successor to the single-key debouncer used on the board top level.
- Handles N_KEYS raw active-low push buttons in one block. Each key gets a synchroniser, a debounce filter, press and release edge pulses, and an optional hold-to-repeat generator.
- Feeds menu navigation (select/back/up/down) so that holding up or down auto-steps gain, band and offset values.

---
 rtl/key_debounce_repeat.sv | 159 +++++++++++++++
 tb/tb_key_debounce_repeat.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/key_debounce_repeat.sv
// Debouncer for N_KEYS active-low push buttons. Each key has a synchroniser, a filter,
// press/release pulses and an optional hold-to-repeat generator.
module key_debounce_repeat #(
  parameter int                N_KEYS        = 4,
  parameter int                SYNC_STAGES   = 2,
  parameter int                DEB_CYCLES    = 16384,
  parameter int                REPEAT_DELAY  = 1000000,
  parameter int                REPEAT_PERIOD = 250000,
  parameter logic [N_KEYS-1:0] REPEAT_MASK   = N_KEYS'(4'b0011)
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [N_KEYS-1:0] i_key,
  output logic [N_KEYS-1:0] o_level,
  output logic [N_KEYS-1:0] o_neg,
  output logic [N_KEYS-1:0] o_pos,
  output logic [N_KEYS-1:0] o_repeat,
  output logic [N_KEYS-1:0] o_evt
);

  // state     | meaning
  // ST_IDLE   | key released, or auto-repeat disabled for this key
  // ST_DELAY  | pressed, waiting REPEAT_DELAY cycles for the first repeat
  // ST_REPEAT | pressed, one repeat pulse every REPEAT_PERIOD cycles
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);
  localparam int RC_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RC_W   = $clog2(RC_MAX + 1);

  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);
  localparam logic [RC_W-1:0]  DLY_LAST = RC_W'(REPEAT_DELAY - 1);
  localparam logic [RC_W-1:0]  PER_LAST = RC_W'(REPEAT_PERIOD - 1);

  for (genvar k = 0; k < N_KEYS; k++) begin : g_key
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_stable;
    logic [DEB_W-1:0]       r_cnt;
    logic                   r_level;
    logic                   r_neg;
    logic                   r_pos;
    logic                   r_repeat;
    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [RC_W-1:0]        r_rc;
    logic [RC_W-1:0]        w_rc_nxt;
    logic                   w_s;
    logic                   w_press;
    logic                   w_release;
    logic                   w_fire;

    assign w_s = r_sync[SYNC_STAGES-1];

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_sync   <= '1;
        r_stable <= 1'b1;
        r_cnt    <= '0;
      end else begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], i_key[k]};
        if (w_s == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == DEB_LAST) begin
          r_stable <= w_s;
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end

    // r_stable keeps raw polarity; the pulses fire while r_level catches up with it
    assign w_press   = ~r_stable & ~r_level;
    assign w_release = r_stable & r_level;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_level <= 1'b0;
        r_neg   <= 1'b0;
        r_pos   <= 1'b0;
      end else begin
        r_level <= ~r_stable;
        r_neg   <= w_press;
        r_pos   <= w_release;
      end
    end

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_state  <= ST_IDLE;
        r_rc     <= '0;
        r_repeat <= 1'b0;
      end else begin
        r_state  <= w_state_nxt;
        r_rc     <= w_rc_nxt;
        r_repeat <= w_fire;
      end
    end

    always_comb begin
      w_state_nxt = r_state;
      w_rc_nxt    = r_rc;
      if (w_release) begin
        w_state_nxt = ST_IDLE;
        w_rc_nxt    = '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (w_press && REPEAT_MASK[k]) begin
              w_state_nxt = ST_DELAY;
              w_rc_nxt    = '0;
            end
          end
          ST_DELAY: begin
            if (r_rc == DLY_LAST) begin
              w_state_nxt = ST_REPEAT;
              w_rc_nxt    = '0;
            end else begin
              w_rc_nxt = r_rc + 1'b1;
            end
          end
          ST_REPEAT: begin
            if (r_rc == PER_LAST) begin
              w_rc_nxt = '0;
            end else begin
              w_rc_nxt = r_rc + 1'b1;
            end
          end
          default: begin
            w_state_nxt = ST_IDLE;
            w_rc_nxt    = '0;
          end
        endcase
      end
    end

    always_comb begin
      w_fire = 1'b0;
      if (!w_release) begin
        case (r_state)
          ST_DELAY:  w_fire = (r_rc == DLY_LAST);
          ST_REPEAT: w_fire = (r_rc == PER_LAST);
          default:   w_fire = 1'b0;
        endcase
      end
    end

    assign o_level[k]  = r_level;
    assign o_neg[k]    = r_neg;
    assign o_pos[k]    = r_pos;
    assign o_repeat[k] = r_repeat;
    assign o_evt[k]    = r_neg | r_repeat;
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Bench for key_debounce_repeat: vector table, timed hand sequences, and random
// stimulus checked against a timestamp-based reference model.
module tb_key_debounce_repeat;

  localparam int         NK   = 4;
  localparam int         SYNC = 2;
  localparam int         DEB  = 4;
  localparam int         RD   = 10;
  localparam int         RP   = 3;
  localparam logic [3:0] MASK = 4'b0011;
  localparam int         LAT  = SYNC + DEB;

  logic          clk = 1'b0;
  logic          i_rst;
  logic [NK-1:0] i_key;
  logic [NK-1:0] o_level, o_neg, o_pos, o_repeat, o_evt;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  key_debounce_repeat #(
    .N_KEYS       (NK),
    .SYNC_STAGES  (SYNC),
    .DEB_CYCLES   (DEB),
    .REPEAT_DELAY (RD),
    .REPEAT_PERIOD(RP),
    .REPEAT_MASK  (MASK)
  ) dut (
    .i_clk   (clk),
    .i_rst   (i_rst),
    .i_key   (i_key),
    .o_level (o_level),
    .o_neg   (o_neg),
    .o_pos   (o_pos),
    .o_repeat(o_repeat),
    .o_evt   (o_evt)
  );

  typedef struct {
    logic       rst;
    logic [3:0] key;
    int         n;
    logic [3:0] lvl;
    logic [3:0] neg;
    logic [3:0] pos;
    logic [3:0] rep;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic [3:0] k, input int n,
                     input logic [3:0] l, input logic [3:0] ng,
                     input logic [3:0] ps, input logic [3:0] rp);
    vec_t v;
    v.rst = r; v.key = k; v.n = n;
    v.lvl = l; v.neg = ng; v.pos = ps; v.rep = rp;
    tbl.push_back(v);
  endtask

  // Drive inputs on the falling edge, then observe just after the next rising edge.
  task automatic step(input logic r, input logic [3:0] k);
    @(negedge clk);
    i_rst = r;
    i_key = k;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%b expected=%b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string nm, input logic [3:0] l, input logic [3:0] ng,
                         input logic [3:0] ps, input logic [3:0] rp);
    chk({nm, ".level"},  o_level,  l);
    chk({nm, ".neg"},    o_neg,    ng);
    chk({nm, ".pos"},    o_pos,    ps);
    chk({nm, ".repeat"}, o_repeat, rp);
    chk({nm, ".evt"},    o_evt,    ng | rp);
  endtask

  // Press 'keys' for 'hold' cycles from offset 0; expectations come straight from the timing rules.
  task automatic hand_seq(input string nm, input logic [3:0] keys, input int hold, input int total);
    for (int o = 0; o < total; o++) begin
      logic [3:0] l, ng, ps, rp;
      step(1'b0, (o < hold) ? ~keys : 4'hF);
      l  = (o >= LAT && o < hold + LAT) ? keys : 4'h0;
      ng = (o == LAT) ? keys : 4'h0;
      ps = (o == hold + LAT) ? keys : 4'h0;
      rp = (o >= LAT + RD && o < hold + LAT && ((o - LAT - RD) % RP) == 0) ? (keys & MASK) : 4'h0;
      chk_all($sformatf("%s.%0d", nm, o), l, ng, ps, rp);
    end
  endtask

  // Reference model: run-length of raw samples differing from the accepted level;
  // an acceptance becomes visible LAT-DEB+1 edges later, repeats follow by arithmetic.
  int   cyc = 0;
  int   m_run[NK];
  logic m_acc[NK];
  logic m_lvl[NK];
  bit   m_pv[NK];
  int   m_pc[NK];
  logic m_pval[NK];
  int   m_press[NK];

  task automatic model_edge(input logic r, input logic [3:0] key,
                            output logic [3:0] el, output logic [3:0] en,
                            output logic [3:0] ep, output logic [3:0] er);
    el = '0; en = '0; ep = '0; er = '0;
    for (int k = 0; k < NK; k++) begin
      if (r) begin
        m_run[k] = 0; m_acc[k] = 1'b1; m_lvl[k] = 1'b0;
        m_pv[k] = 1'b0; m_press[k] = -1000;
      end else begin
        if (m_pv[k] && m_pc[k] == cyc) begin
          m_pv[k] = 1'b0;
          if (m_pval[k] == 1'b0) begin
            m_lvl[k] = 1'b1; en[k] = 1'b1; m_press[k] = cyc;
          end else begin
            m_lvl[k] = 1'b0; ep[k] = 1'b1;
          end
        end
        if (key[k] != m_acc[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == DEB) begin
          m_acc[k] = key[k]; m_run[k] = 0;
          m_pv[k] = 1'b1; m_pc[k] = cyc + SYNC + 1; m_pval[k] = key[k];
        end
        er[k] = MASK[k] && m_lvl[k] && (cyc >= m_press[k] + RD) &&
                (((cyc - m_press[k] - RD) % RP) == 0);
      end
      el[k] = m_lvl[k];
    end
    cyc++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic       r;
    logic [3:0] el, en, ep, er;
    logic [3:0] rkey;
    int         hl[NK];
    int         rst_left;

    i_rst = 1'b1;
    i_key = 4'hF;

    // reset, clean press/release on key 2 (no repeat), glitch and minimum-length press on key 0
    add(1, 4'hF,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hB,  6, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hB,  1, 4'h4, 4'h4, 4'h0, 4'h0);
    add(0, 4'hB, 29, 4'h4, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF,  6, 4'h4, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF,  1, 4'h0, 4'h0, 4'h4, 4'h0);
    add(0, 4'hF,  4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hE,  3, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF, 10, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hE,  4, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF,  2, 4'h0, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF,  1, 4'h1, 4'h1, 4'h0, 4'h0);
    add(0, 4'hF,  3, 4'h1, 4'h0, 4'h0, 4'h0);
    add(0, 4'hF,  1, 4'h0, 4'h0, 4'h1, 4'h0);
    add(0, 4'hF,  4, 4'h0, 4'h0, 4'h0, 4'h0);

    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        step(tbl[i].rst, tbl[i].key);
        chk_all($sformatf("tbl%0d.%0d", i, c), tbl[i].lvl, tbl[i].neg, tbl[i].pos, tbl[i].rep);
      end
    end

    // release lands exactly on a repeat slot (offset 43), which must stay quiet
    hand_seq("autorep", 4'b0010, 37, 50);
    hand_seq("simul",   4'b1001, 20, 32);

    // reset while key 0 is repeating, key held through reset release
    for (int o = 0; o < 56; o++) begin
      logic [3:0] l, ng, rp;
      int q;
      r = (o == 24 || o == 25);
      step(r, 4'hE);
      q  = (o < 24) ? o : o - 26;
      l  = (!r && q >= LAT) ? 4'h1 : 4'h0;
      ng = (!r && q == LAT) ? 4'h1 : 4'h0;
      rp = (!r && q >= LAT + RD && ((q - LAT - RD) % RP) == 0) ? 4'h1 : 4'h0;
      chk_all($sformatf("rstmid.%0d", o), l, ng, 4'h0, rp);
    end
    repeat (12) step(1'b0, 4'hF);

    // randomized phase against the reference model
    rkey = 4'hF;
    rst_left = 2;
    for (int k = 0; k < NK; k++) hl[k] = $urandom_range(1, 40);
    for (int c = 0; c < 3000; c++) begin
      for (int k = 0; k < NK; k++) begin
        hl[k]--;
        if (hl[k] <= 0) begin
          rkey[k] = ~rkey[k];
          hl[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : $urandom_range(4, 45);
        end
      end
      if (rst_left == 0 && $urandom_range(0, 399) == 0) rst_left = $urandom_range(1, 3);
      r = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      step(r, rkey);
      model_edge(r, rkey, el, en, ep, er);
      chk_all($sformatf("rnd%0d", c), el, en, ep, er);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
